dataflow_accumulator: RTL and testbench
=======================================

DATAFLOW_ACCUMULATOR -- requirements
Module: dataflow_accumulator

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, 8, input sample width.
- ACC_COUNT, 4, samples summed per result; legal range 2..256.
REQ-002 Derived constant ACC_WIDTH SHALL equal DATA_WIDTH + $clog2(ACC_COUNT).
REQ-003 Ports SHALL be, one per line:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block accepts sample this cycle.
- data_in  input  DATA_WIDTH  unsigned sample, typically the upstream constant-multiply product.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- data_out  output  ACC_WIDTH  unsigned sum of ACC_COUNT samples.
- clear  input  1  present only with ACC_CLEAR_EN; drops the partial sum.

Function
REQ-004 A beat SHALL be accepted when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-005 Internal state SHALL be:
- acc (ACC_WIDTH bits): partial sum.
- cnt (counts 0..ACC_COUNT-1): beats accepted in the current group.
- Output register: data_out and out_valid.
REQ-006 A non-final accepted beat (cnt < ACC_COUNT-1) SHALL update acc <= acc + data_in and cnt <= cnt + 1.
REQ-007 A final accepted beat (cnt == ACC_COUNT-1) SHALL load data_out <= acc + data_in, set out_valid <= 1, and clear acc and cnt to 0 in the same edge.
REQ-008 in_ready SHALL be combinational: (cnt != ACC_COUNT-1) || !out_valid || out_ready. Non-final beats are never stalled by a held output.
REQ-009 On an output transfer with no simultaneous final beat, out_valid SHALL go to 0 on the next edge.
REQ-010 A final beat coinciding with an output transfer SHALL reload data_out and keep out_valid at 1, with no bubble.
REQ-011 Latency SHALL be one cycle from acceptance of the final beat to out_valid high. Sustained throughput SHALL be one beat per cycle while out_ready is held at 1.
REQ-012 The sum SHALL never overflow: ACC_WIDTH holds ACC_COUNT*(2^DATA_WIDTH-1). No wrap or saturation logic is required.
REQ-013 data_out and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-014 in_ready SHALL NOT depend on in_valid. in_valid SHALL be ignored while in_ready is 0.

Reset
REQ-015 rst_n low SHALL asynchronously force acc=0, cnt=0, out_valid=0 and data_out=0. in_ready therefore reads 1.
REQ-016 Reset mid-group SHALL discard the partial sum and any held result. The first beat after reset release SHALL start a new group.

Configuration
REQ-017 With macro ACC_CLEAR_EN defined:
- Port clear SHALL exist.
- clear high SHALL force in_ready=0 and set acc<=0, cnt<=0 on the next edge.
- The output register and any pending output transfer SHALL be unaffected.
REQ-018 With ACC_CLEAR_EN undefined, port clear and all associated logic SHALL be absent. Behaviour is otherwise identical.

Structure
REQ-019 Package dataflow_pkg SHALL hold a function acc_width(data_width, count) returning ACC_WIDTH, shared with the other dataflow stages.
REQ-020 The block SHALL be a single module with no sub-modules. The counter and output register are inline.

Verification (DATA_WIDTH=8, ACC_COUNT=4)
REQ-021 Samples 1,2,3,4 on consecutive cycles with out_ready=1 -> data_out=10 with out_valid high one cycle after the 4th beat.
REQ-022 Four samples of 255 -> data_out=1020 (10-bit), with no overflow.
REQ-023 out_ready=0 held and 7 beats offered -> beats 5..7 accepted (cnt 0..2). The 8th beat SHALL see in_ready=0 until out_ready=1, then complete with no bubble. First result SHALL be held stable throughout.
REQ-024 Continuous 12 beats of value 5 with out_ready=1 -> three results of 20 on cycles 5, 9 and 13, with in_ready constantly 1.
REQ-025 rst_n pulsed low after 2 of 4 beats -> out_valid=0 immediately. The next 4 beats of 1 SHALL give data_out=4.
REQ-026 With ACC_CLEAR_EN: beats 9,9 then clear for 1 cycle, then 1,1,1,1 -> data_out=4. The clear-cycle in_ready SHALL be 0.

Source files
------------

// File: rtl/dataflow_pkg.sv
// Shared helpers for the dataflow pipeline stages.
package dataflow_pkg;

  // Sum of `count` unsigned samples of `data_width` bits never overflows this width.
  function automatic int acc_width(input int data_width, input int count);
    return data_width + $clog2(count);
  endfunction

endpackage

// File: rtl/dataflow_accumulator.sv
// Sums groups of ACC_COUNT unsigned samples into one registered result (valid/ready both sides).
// Optional macro ACC_CLEAR_EN adds a 'clear' input that drops the partial sum.
module dataflow_accumulator
  import dataflow_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_COUNT  = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [DATA_WIDTH-1:0]                          data_in,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [acc_width(DATA_WIDTH, ACC_COUNT)-1:0]    data_out
`ifdef ACC_CLEAR_EN
  ,
  input  logic                                           clear
`endif
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ACC_COUNT);
  localparam int CNT_W     = $clog2(ACC_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_COUNT - 1);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [ACC_WIDTH-1:0] r_data_out;
  logic                 r_out_valid;

  logic                 w_last;
  logic                 w_accept;
  logic                 w_out_xfer;
  logic                 w_clear;
  logic [ACC_WIDTH-1:0] w_sum;

`ifdef ACC_CLEAR_EN
  assign w_clear = clear;
`else
  assign w_clear = 1'b0;
`endif

  // Only the final beat of a group needs the output register free.
  assign w_last     = (r_cnt == CNT_LAST);
  assign in_ready   = (!w_last || !r_out_valid || out_ready) && !w_clear;
  assign w_accept   = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_sum      = r_acc + ACC_WIDTH'(data_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Output register: a final beat reloads it even while the old result leaves, so no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept && w_last) begin
      r_data_out  <= w_sum;
      r_out_valid <= 1'b1;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_dataflow_accumulator.sv
// Self-checking bench for dataflow_accumulator (DATA_WIDTH=8, ACC_COUNT=4); covers 'clear' when ACC_CLEAR_EN is defined.
module tb_dataflow_accumulator;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] data_out;
  logic          clr = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dataflow_accumulator #(.DATA_WIDTH(DW), .ACC_COUNT(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out)
`ifdef ACC_CLEAR_EN
    ,
    .clear    (clr)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: accepted samples collect into groups of N; each full group becomes
  // one pending result that is presented until the downstream takes it.
  int grp[$];
  int res_q[$];

  always @(negedge clk) begin
    int s;
    bit exp_rdy;
    if (!rst_n) begin
      grp.delete();
      res_q.delete();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_data_out", 32'(data_out), 32'd0);
    end else begin
      exp_rdy = !((grp.size() == N - 1) && (res_q.size() > 0) && !out_ready) && !clr;
      check("model_in_ready", 32'(in_ready), 32'(exp_rdy));
      check("model_out_valid", 32'(out_valid), 32'(res_q.size() > 0));
      if (res_q.size() > 0) check("model_data_out", 32'(data_out), 32'(res_q[0]));
      if (res_q.size() > 0 && out_ready) void'(res_q.pop_front());
      if (clr) begin
        grp.delete();
      end else if (in_valid && exp_rdy) begin
        grp.push_back(int'(data_in));
        if (grp.size() == N) begin
          s = 0;
          foreach (grp[i]) s += grp[i];
          res_q.push_back(s);
          grp.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int nres;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    #11 rst_n = 1'b1;
    tick();

    // Samples 1..4 -> 10, visible right after the 4th accepting edge.
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      in_valid = 1'b1; data_in = DW'(v);
      tick();
    end
    in_valid = 1'b0;
    check("sum_1234_valid", 32'(out_valid), 32'd1);
    check("sum_1234", 32'(data_out), 32'd10);
    tick();
    check("sum_1234_drained", 32'(out_valid), 32'd0);

    // Full-scale samples fill the 10-bit result exactly.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; data_in = 8'd255;
      tick();
    end
    in_valid = 1'b0;
    check("sum_max", 32'(data_out), 32'd1020);
    tick();

    // 12 back-to-back beats of 5: results of 20 after beats 4, 8, 12, never stalled.
    nres = 0;
    for (int i = 1; i <= 12; i++) begin
      in_valid = 1'b1; data_in = 8'd5;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      if (out_valid) begin
        nres++;
        check("stream_result_cycle", 32'(i % 4), 32'd0);
        check("stream_result", 32'(data_out), 32'd20);
      end
    end
    in_valid = 1'b0;
    check("stream_result_count", 32'(nres), 32'd3);
    tick();

    // Held output: beats 5..7 still accepted, the 8th waits for out_ready.
    out_ready = 1'b0;
    for (int v = 1; v <= 7; v++) begin
      in_valid = 1'b1; data_in = DW'(v);
      check("hold_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    check("hold_first_result", 32'(data_out), 32'd10);
    data_in = 8'd8;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_stall_ready", 32'(in_ready), 32'd0);
      check("hold_stable_valid", 32'(out_valid), 32'd1);
      check("hold_stable_data", 32'(data_out), 32'd10);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("hold_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("no_bubble_valid", 32'(out_valid), 32'd1);
    check("no_bubble_data", 32'(data_out), 32'd26);
    tick();
    check("hold_drained", 32'(out_valid), 32'd0);

    // Reset with a held result and a partial group pending.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; data_in = (k < 4) ? 8'd2 : 8'd3;
      tick();
    end
    in_valid = 1'b0;
    check("pre_reset_held", 32'(data_out), 32'd8);
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; data_in = 8'd1;
      tick();
    end
    in_valid = 1'b0;
    check("post_reset_sum", 32'(data_out), 32'd4);
    check("post_reset_valid", 32'(out_valid), 32'd1);
    tick();

`ifdef ACC_CLEAR_EN
    // Clear drops the partial 9+9; the held-in-flight beat during clear is ignored.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; data_in = 8'd9;
      tick();
    end
    clr = 1'b1;
    #1;
    check("clear_in_ready", 32'(in_ready), 32'd0);
    tick();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; data_in = 8'd1;
      tick();
    end
    in_valid = 1'b0;
    check("clear_sum", 32'(data_out), 32'd4);
    tick();
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
